// File: rtl/median_frame_sched.sv
// Raster-stream scheduler feeding a 3x3 window into a 9-input median engine, one job at a time.
// Optional engine watchdog enabled by defining MEDIAN_SCHED_TIMEOUT_EN.
module median_frame_sched #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int TMO   = 63
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] PIX_IN,
  input  logic             PIX_VLD,
  output logic             PIX_RDY,
  output logic [WIDTH-1:0] MED_DI,
  output logic             MED_DSI,
  input  logic [WIDTH-1:0] MED_DO,
  input  logic             MED_DSO,
  output logic [WIDTH-1:0] OUT_PIX,
  output logic             OUT_VLD,
  input  logic             OUT_RDY,
  output logic             EOF,
  output logic             BUSY,
  output logic             ERR
);
  // state | meaning
  // IDLE  | accepting pixels, building lines and window
  // LOAD  | streaming 9 window pixels to the engine
  // WAIT  | waiting for the engine result strobe
  // OUT   | presenting the median until the consumer takes it
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [3:0]       cnt;
  logic             last_win;
  logic [WIDTH-1:0] lb0 [IMG_W];
  logic [WIDTH-1:0] lb1 [IMG_W];
  logic [WIDTH-1:0] win [9];
  logic             accept;

`ifdef MEDIAN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  assign accept = (state == IDLE) && PIX_VLD && PIX_RDY;

  // Storage is never read before being written in the current frame, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r*3]   <= win[r*3+1];
        win[r*3+1] <= win[r*3+2];
      end
      win[2]   <= lb0[col];
      win[5]   <= lb1[col];
      win[8]   <= PIX_IN;
      lb0[col] <= lb1[col];
      lb1[col] <= PIX_IN;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      cnt      <= '0;
      last_win <= 1'b0;
      PIX_RDY  <= 1'b0;
      MED_DSI  <= 1'b0;
      MED_DI   <= '0;
      OUT_VLD  <= 1'b0;
      OUT_PIX  <= '0;
      EOF      <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          PIX_RDY <= 1'b1;
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (row >= RW'(2) && col >= CW'(2)) begin
              // Window shifts on this same edge, so top-left after the shift is win[1] now.
              state    <= LOAD;
              PIX_RDY  <= 1'b0;
              BUSY     <= 1'b1;
              MED_DSI  <= 1'b1;
              MED_DI   <= win[1];
              cnt      <= '0;
              last_win <= (row == ROW_LAST) && (col == COL_LAST);
            end
          end
        end
        LOAD: begin
          if (cnt == 4'd8) begin
            MED_DSI <= 1'b0;
            MED_DI  <= '0;
            state   <= WAIT;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
            tmo_cnt <= TW'(TMO - 1);
`endif
          end else begin
            cnt    <= cnt + 4'd1;
            MED_DI <= win[cnt + 4'd1];
          end
        end
        WAIT: begin
          if (MED_DSO) begin
            OUT_PIX <= MED_DO;
            OUT_VLD <= 1'b1;
            EOF     <= last_win;
            state   <= OUT;
          end
`ifdef MEDIAN_SCHED_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            ERR     <= 1'b1;
            OUT_PIX <= '0;
            OUT_VLD <= 1'b1;
            EOF     <= last_win;
            state   <= OUT;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
`endif
        end
        OUT: begin
          if (OUT_RDY) begin
            OUT_VLD <= 1'b0;
            EOF     <= 1'b0;
            BUSY    <= 1'b0;
            PIX_RDY <= 1'b1;
            state   <= IDLE;
            if (last_win) begin
              row <= '0;
              col <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_frame_sched.sv
// Scoreboard bench for median_frame_sched on a 4x4 image with a behavioural median engine.
module tb_median_frame_sched;
  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] PIX_IN;
  logic       PIX_VLD;
  logic       PIX_RDY;
  logic [7:0] MED_DI;
  logic       MED_DSI;
  logic [7:0] MED_DO = 8'd0;
  logic       MED_DSO = 1'b0;
  logic [7:0] OUT_PIX;
  logic       OUT_VLD;
  logic       OUT_RDY;
  logic       EOF;
  logic       BUSY;
  logic       ERR;

  median_frame_sched #(.WIDTH(8), .IMG_W(4), .IMG_H(4), .TMO(63)) dut (
    .CLK(CLK), .nRST(nRST), .PIX_IN(PIX_IN), .PIX_VLD(PIX_VLD), .PIX_RDY(PIX_RDY),
    .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_DO(MED_DO), .MED_DSO(MED_DSO),
    .OUT_PIX(OUT_PIX), .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY), .EOF(EOF),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int eof_cnt = 0;
  logic eng_en = 1'b1;
  logic [8:0]      exp_q [$];
  logic [8:0][7:0] win_q [$];
  logic [7:0] fa [16];
  logic [7:0] fb [16];
  logic [7:0] cur [16];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] med9(input logic [8:0][7:0] v);
    logic [7:0] s [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) s[i] = v[i];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[4];
  endfunction

  // Behavioural engine: collects 9 DSI words, answers 3 cycles later.
  logic [8:0][7:0] got;
  int ecnt = 0;
  int lat = 0;
  always @(negedge CLK) begin
    if (!nRST) begin
      ecnt = 0;
      lat = 0;
      MED_DSO = 1'b0;
    end else begin
      MED_DSO = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          MED_DO = med9(got);
          MED_DSO = 1'b1;
        end
      end
      if (MED_DSI) begin
        got[ecnt] = MED_DI;
        ecnt++;
        if (ecnt == 9) begin
          logic [8:0][7:0] w;
          ecnt = 0;
          if (win_q.size() == 0) chk(1'b0, "dsi_unexpected_burst", 1, 0);
          else begin
            w = win_q.pop_front();
            chk(got == w, "dsi_window_order", int'(got[0]), int'(w[0]));
          end
          if (eng_en) lat = 3;
        end
      end
    end
  end

  // Output monitor
  always @(negedge CLK) begin
    if (nRST && OUT_VLD && OUT_RDY) begin
      logic [8:0] e;
      if (exp_q.size() == 0) chk(1'b0, "out_unexpected", int'(OUT_PIX), -1);
      else begin
        e = exp_q.pop_front();
        chk(OUT_PIX === e[7:0], "out_pix", int'(OUT_PIX), int'(e[7:0]));
        chk(EOF === e[8], "out_eof", int'(EOF), int'(e[8]));
      end
      if (EOF) eof_cnt++;
    end
  end

  task automatic push_frame(input logic [7:0] m0, input logic [7:0] m1,
                            input logic [7:0] m2, input logic [7:0] m3);
    logic [8:0][7:0] w;
    logic [7:0] m [4];
    m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
    for (int r = 1; r <= 2; r++)
      for (int c = 1; c <= 2; c++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[i*3+j] = cur[(r-1+i)*4 + c-1+j];
        win_q.push_back(w);
        exp_q.push_back({(r == 2 && c == 2), eng_en ? m[(r-1)*2 + c-1] : 8'd0});
      end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] v);
    int k;
    PIX_IN = v;
    PIX_VLD = 1'b1;
    k = 0;
    while (!PIX_RDY && k < 1000) begin @(posedge CLK); #1; k++; end
    if (!PIX_RDY) begin
      chk(1'b0, "send_timeout", k, 1000);
      $fatal(1, "stalled input");
    end
    @(posedge CLK); #1;
    PIX_VLD = 1'b0;
  endtask

  task automatic stream(input int first, input int last);
    for (int i = first; i <= last; i++) send(cur[i]);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || win_q.size() != 0) && k < 500) begin
      @(posedge CLK); #1; k++;
    end
    chk(exp_q.size() == 0 && win_q.size() == 0, "drain", exp_q.size() + win_q.size(), 0);
  endtask

  initial begin
    int e0, n;
    bit ok;
    logic [7:0] p;
    for (int i = 0; i < 16; i++) fa[i] = 8'(i);
    fb = '{8'd9, 8'd1, 8'd8, 8'd200, 8'd2, 8'd7, 8'd3, 8'd0,
           8'd6, 8'd4, 8'd5, 8'd255, 8'd10, 8'd20, 8'd30, 8'd40};
    nRST = 1'b0; PIX_IN = 8'd0; PIX_VLD = 1'b0; OUT_RDY = 1'b1;
    repeat (3) @(negedge CLK);
    chk(PIX_RDY == 1'b0, "rst_pix_rdy", int'(PIX_RDY), 0);
    chk(MED_DSI == 1'b0 && MED_DI == 8'd0, "rst_med", int'(MED_DSI), 0);
    chk(OUT_VLD == 1'b0 && OUT_PIX == 8'd0 && EOF == 1'b0, "rst_out", int'(OUT_VLD), 0);
    chk(BUSY == 1'b0 && ERR == 1'b0, "rst_busy_err", int'(BUSY), 0);
    nRST = 1'b1;
    @(posedge CLK); #1;
    chk(PIX_RDY == 1'b1 && BUSY == 1'b0, "idle_pix_rdy", int'(PIX_RDY), 1);

    // Frame A then frame B back-to-back
    cur = fa;
    push_frame(8'd5, 8'd6, 8'd9, 8'd10);
    stream(0, 10);
    chk(MED_DSI == 1'b1 && MED_DI == 8'd0, "first_dsi_latency", int'(MED_DSI), 1);
    chk(BUSY == 1'b1 && PIX_RDY == 1'b0, "load_busy", int'(BUSY), 1);
    stream(11, 15);
    cur = fb;
    push_frame(8'd5, 8'd5, 8'd6, 8'd7);
    stream(0, 15);
    drain();
    chk(eof_cnt == 2, "eof_twice", eof_cnt, 2);

    // Output stall of 20 cycles on the first median
    cur = fa;
    push_frame(8'd5, 8'd6, 8'd9, 8'd10);
    OUT_RDY = 1'b0;
    fork
      stream(0, 15);
      begin
        n = 0;
        while (!OUT_VLD && n < 300) begin @(posedge CLK); #1; n++; end
        chk(OUT_VLD == 1'b1, "stall_out_seen", int'(OUT_VLD), 1);
        p = OUT_PIX;
        ok = 1'b1;
        repeat (20) begin
          @(posedge CLK); #1;
          if (!OUT_VLD || OUT_PIX != p || PIX_RDY || MED_DSI) ok = 1'b0;
        end
        chk(ok, "stall_hold", int'(OUT_PIX), int'(p));
        OUT_RDY = 1'b1;
      end
    join
    drain();
    e0 = eof_cnt;
    chk(e0 == 3, "eof_after_stall", e0, 3);

    // Reset during LOAD at C=4
    cur = fa;
    stream(0, 10);
    repeat (4) @(posedge CLK);
    #1;
    chk(MED_DSI == 1'b1 && MED_DI == cur[5], "load_c4_center", int'(MED_DI), int'(cur[5]));
    nRST = 1'b0;
    #1;
    chk(MED_DSI == 1'b0 && OUT_VLD == 1'b0 && BUSY == 1'b0, "rst_mid_load", int'(MED_DSI), 0);
    exp_q.delete();
    win_q.delete();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    push_frame(8'd5, 8'd6, 8'd9, 8'd10);
    stream(0, 15);
    drain();
    chk(eof_cnt == e0 + 1, "eof_after_reset", eof_cnt, e0 + 1);
    chk(ERR == 1'b0, "err_clear", int'(ERR), 0);

`ifdef MEDIAN_SCHED_TIMEOUT_EN
    // Engine silent: watchdog fires after 63 WAIT cycles
    eng_en = 1'b0;
    cur = fa;
    push_frame(8'd5, 8'd6, 8'd9, 8'd10);
    stream(0, 10);
    n = 0;
    while (!OUT_VLD && n < 300) begin @(posedge CLK); #1; n++; end
    chk(n == 72, "tmo_latency", n, 72);
    chk(ERR == 1'b1 && OUT_PIX == 8'd0, "tmo_err_pix", int'(ERR), 1);
    stream(11, 15);
    drain();
    chk(eof_cnt == e0 + 2, "tmo_eof", eof_cnt, e0 + 2);
    chk(ERR == 1'b1, "tmo_sticky", int'(ERR), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
